key_event_fifo: RTL and testbench

//  Downstream consumer of the keypad row/column scanner. Takes its level-type
//  "key held + code" output and debounces it into one press event per key

---
 rtl/key_event_fifo_if.sv | 27 ++
 rtl/key_event_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_key_event_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_fifo_if.sv
// Key-event FIFO bus: scanner-side key level/code in, consumer pop/status out.
// The master modport is the scanner/consumer side; the slave modport is the FIFO.
interface key_event_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          key_down;
  logic [3:0]    key_code;
  logic          rd_en;
  logic [3:0]    rd_data;
  logic          rd_valid;
  logic          full;
  logic          overflow;
  logic [CW-1:0] count;
  logic [7:0]    diods;

  modport master (
    output key_down, key_code, rd_en,
    input  rd_data, rd_valid, full, overflow, count, diods
  );

  modport slave (
    input  key_down, key_code, rd_en,
    output rd_data, rd_valid, full, overflow, count, diods
  );
endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo: debounces the keypad scanner's held/code level into one
// event per press and queues events in a first-word-fall-through FIFO.
// Optional macro KEY_REPEAT_EN adds auto-repeat of the held code.
// After reset the key must be seen released once before a press is accepted,
// so a key held through reset produces no event until it is re-pressed.
module key_event_fifo #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input logic             clk,
  input logic             rst,
  key_event_fifo_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_event_fifo: DEPTH must be a power of two >= 2");
  end
  if (DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_timing
    $error("key_event_fifo: DEBOUNCE/REPEAT_DELAY/REPEAT_RATE must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  // Synchronizers and arming
  logic          kd_s1, kd;
  logic [3:0]    code_s1, code_s;
  logic [1:0]    sync_fill;
  logic          armed, armed_n;

  // Debounce FSM
  state_t        state, state_n;
  logic [DBW-1:0] db_cnt, db_cnt_n;
  logic [3:0]    cap_code, cap_code_n;
  logic          push_req;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPW  = $clog2(RMAX + 1);
  logic [RPW-1:0] rep_cnt, rep_cnt_n;
  logic           rep_first, rep_first_n;
`endif

  // FIFO storage and registered outputs
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [3:0]    rd_data, head_n;
  logic          rd_valid, valid_n;
  logic          full, full_n;
  logic          overflow, ovf_n;
  logic [3:0]    last_code, last_code_n;
  logic [7:0]    diods, diods_n;
  logic          push_ok, pop_ok;

  // Two-flop synchronizers; sync_fill marks when kd carries a real sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kd_s1     <= 1'b0;
      kd        <= 1'b0;
      code_s1   <= '0;
      code_s    <= '0;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      kd_s1     <= bus.key_down;
      kd        <= kd_s1;
      code_s1   <= bus.key_code;
      code_s    <= code_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed_n;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      db_cnt   <= '0;
      cap_code <= '0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      db_cnt   <= db_cnt_n;
      cap_code <= cap_code_n;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
`endif
    end
  end

  // FSM next state and push request
  always_comb begin
    state_n    = state;
    db_cnt_n   = db_cnt;
    cap_code_n = cap_code;
    push_req   = 1'b0;
    armed_n    = armed | (sync_fill[1] & ~kd);
`ifdef KEY_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
`endif
    unique case (state)
      S_IDLE: begin
        if (kd && armed) begin
          state_n    = S_PRESS_DB;
          db_cnt_n   = '0;
          cap_code_n = code_s;
        end
      end
      S_PRESS_DB: begin
        if (!kd) begin
          state_n = S_IDLE;
        end else if (db_cnt == DBW'(DEBOUNCE - 1)) begin
          state_n  = S_HELD;
          push_req = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_cnt_n   = '0;
          rep_first_n = 1'b0;
`endif
        end else begin
          db_cnt_n = db_cnt + DBW'(1);
        end
      end
      S_HELD: begin
        if (!kd) begin
          state_n  = S_REL_DB;
          db_cnt_n = '0;
        end
`ifdef KEY_REPEAT_EN
        else if ((!rep_first && rep_cnt == RPW'(REPEAT_DELAY - 1)) ||
                 ( rep_first && rep_cnt == RPW'(REPEAT_RATE - 1))) begin
          push_req    = 1'b1;
          rep_cnt_n   = '0;
          rep_first_n = 1'b1;
        end else begin
          rep_cnt_n = rep_cnt + RPW'(1);
        end
`endif
      end
      S_REL_DB: begin
        if (kd) begin
          state_n = S_HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_n   = '0;
          rep_first_n = 1'b0;
`endif
        end else if (db_cnt == DBW'(DEBOUNCE - 1)) begin
          state_n = S_IDLE;
        end else begin
          db_cnt_n = db_cnt + DBW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FIFO next-state: simultaneous pop frees the slot for a push even when full
  always_comb begin
    pop_ok   = bus.rd_en & rd_valid;
    push_ok  = push_req & (~full | pop_ok);
    wr_ptr_n = push_ok ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n = pop_ok  ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count;
    if (push_ok && !pop_ok) begin
      count_n = count + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_n = count - CW'(1);
    end
    valid_n = (count_n != '0);
    full_n  = (count_n == CW'(DEPTH));
    ovf_n   = overflow | (push_req & ~push_ok);
    if (!valid_n) begin
      head_n = '0;
    end else if (push_ok && (wr_ptr == rd_ptr_n)) begin
      head_n = cap_code;
    end else begin
      head_n = mem[rd_ptr_n];
    end
    last_code_n = pop_ok ? rd_data : last_code;
    diods_n     = {ovf_n, full_n, valid_n, 1'b0, last_code_n};
  end

  // FIFO storage, pointers and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      last_code <= '0;
      diods     <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= cap_code;
      end
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      rd_data   <= head_n;
      rd_valid  <= valid_n;
      full      <= full_n;
      overflow  <= ovf_n;
      last_code <= last_code_n;
      diods     <= diods_n;
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.count    = count;
  assign bus.diods    = diods;
endmodule

// File: tb/tb_key_event_fifo.sv
// Directed self-checking bench for key_event_fifo (DEPTH=4, DEBOUNCE=4,
// REPEAT_DELAY=20, REPEAT_RATE=8). Define KEY_REPEAT_EN to exercise auto-repeat.
module tb_key_event_fifo;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned DEBOUNCE     = 4;
  localparam int unsigned REPEAT_DELAY = 20;
  localparam int unsigned REPEAT_RATE  = 8;

  localparam logic [1:0] OP_PRESS  = 2'd0;
  localparam logic [1:0] OP_GLITCH = 2'd1;
  localparam logic [1:0] OP_POP    = 2'd2;
  localparam logic [1:0] OP_BOUNCE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_event_fifo_if #(.DEPTH(DEPTH)) bus ();

  key_event_fifo #(
    .DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] code;
    logic [2:0] count;
    logic       valid;
    logic [3:0] data;
    logic       full;
    logic       ovf;
    logic [7:0] diods;
  } vec_t;

  vec_t vecs [12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [2:0] c, input logic v,
                           input logic [3:0] d, input logic f, input logic o,
                           input logic [7:0] dio);
    chk({nm, ".count"},    8'(bus.count),    8'(c));
    chk({nm, ".rd_valid"}, 8'(bus.rd_valid), 8'(v));
    chk({nm, ".rd_data"},  8'(bus.rd_data),  8'(d));
    chk({nm, ".full"},     8'(bus.full),     8'(f));
    chk({nm, ".overflow"}, 8'(bus.overflow), 8'(o));
    chk({nm, ".diods"},    bus.diods,        dio);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    bus.rd_en = 1'b0;
    rst = 1'b0;
    #2;
    check_all(nm, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick(4);
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_code = code;
    bus.key_down = 1'b1;
    tick(12);
    bus.key_down = 1'b0;
    tick(12);
  endtask

  task automatic glitch(input logic [3:0] code);
    bus.key_code = code;
    bus.key_down = 1'b1;
    tick(3);
    bus.key_down = 1'b0;
    tick(12);
  endtask

  task automatic bounce_press(input logic [3:0] code);
    bus.key_code = code;
    bus.key_down = 1'b1; tick(12);
    bus.key_down = 1'b0; tick(2);
    bus.key_down = 1'b1; tick(2);
    bus.key_down = 1'b0; tick(2);
    bus.key_down = 1'b1; tick(1);
    bus.key_down = 1'b0; tick(14);
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [3:0] drain [4];
    int exp_lat_count;

    bus.key_down = 1'b0;
    bus.key_code = 4'h0;
    bus.rd_en    = 1'b0;

    // Table: starts with empty FIFO, last_code = 7, overflow clear
    vecs[0]  = '{OP_GLITCH, 4'h9, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h07};
    vecs[1]  = '{OP_POP,    4'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h07};
    vecs[2]  = '{OP_PRESS,  4'h1, 3'd1, 1'b1, 4'h1, 1'b0, 1'b0, 8'h27};
    vecs[3]  = '{OP_BOUNCE, 4'h2, 3'd2, 1'b1, 4'h1, 1'b0, 1'b0, 8'h27};
    vecs[4]  = '{OP_PRESS,  4'h3, 3'd3, 1'b1, 4'h1, 1'b0, 1'b0, 8'h27};
    vecs[5]  = '{OP_PRESS,  4'h4, 3'd4, 1'b1, 4'h1, 1'b1, 1'b0, 8'h67};
    vecs[6]  = '{OP_PRESS,  4'h5, 3'd4, 1'b1, 4'h1, 1'b1, 1'b1, 8'hE7};
    vecs[7]  = '{OP_POP,    4'h0, 3'd3, 1'b1, 4'h2, 1'b0, 1'b1, 8'hA1};
    vecs[8]  = '{OP_POP,    4'h0, 3'd2, 1'b1, 4'h3, 1'b0, 1'b1, 8'hA2};
    vecs[9]  = '{OP_POP,    4'h0, 3'd1, 1'b1, 4'h4, 1'b0, 1'b1, 8'hA3};
    vecs[10] = '{OP_POP,    4'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h84};
    vecs[11] = '{OP_POP,    4'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h84};

    do_reset("reset");

    // First-event latency: key sampled at edge 0, event visible after edge 6
    bus.key_code = 4'h7;
    bus.key_down = 1'b1;
    tick(6);
    chk("latency.early_valid", 8'(bus.rd_valid), 8'h00);
    tick(1);
    chk("latency.valid", 8'(bus.rd_valid), 8'h01);
    chk("latency.data",  8'(bus.rd_data),  8'h07);
    chk("latency.count", 8'(bus.count),    8'h01);
    tick(23);
    bus.key_down = 1'b0;
    tick(12);
`ifdef KEY_REPEAT_EN
    exp_lat_count = 2;
`else
    exp_lat_count = 1;
`endif
    chk("long_hold.count", 8'(bus.count), 8'(exp_lat_count));
    for (int i = 0; i < exp_lat_count; i++) pop();
    check_all("long_hold.drained", 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h07);

    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_PRESS:  press(vecs[i].code);
        OP_GLITCH: glitch(vecs[i].code);
        OP_POP:    pop();
        default:   bounce_press(vecs[i].code);
      endcase
      check_all($sformatf("vec%0d", i), vecs[i].count, vecs[i].valid, vecs[i].data,
                vecs[i].full, vecs[i].ovf, vecs[i].diods);
    end

    // Key held through reset: no event until released and pressed again
    bus.key_code = 4'h5;
    bus.key_down = 1'b1;
    do_reset("reset_held");
    tick(30);
    chk("reset_held.count", 8'(bus.count), 8'h00);
    bus.key_down = 1'b0;
    tick(12);
    chk("reset_held.release_count", 8'(bus.count), 8'h00);
    press(4'h5);
    check_all("reset_held.repress", 3'd1, 1'b1, 4'h5, 1'b0, 1'b0, 8'h20);
    pop();

    // Full FIFO, push and pop on the same edge: accepted, no overflow
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    check_all("full4", 3'd4, 1'b1, 4'hA, 1'b1, 1'b0, 8'h65);
    bus.key_code = 4'hE;
    bus.key_down = 1'b1;
    tick(6);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check_all("full_push_pop", 3'd4, 1'b1, 4'hB, 1'b1, 1'b0, 8'h6A);
    bus.key_down = 1'b0;
    tick(12);
    drain[0] = 4'hB; drain[1] = 4'hC; drain[2] = 4'hD; drain[3] = 4'hE;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 8'(bus.rd_data), 8'(drain[i]));
      pop();
    end
    check_all("drained", 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h0E);

`ifdef KEY_REPEAT_EN
    // Auto-repeat: events at accept +0, +20, +28, +36
    do_reset("reset_rep");
    bus.key_code = 4'hA;
    bus.key_down = 1'b1;
    tick(7);
    chk("rep.accept", 8'(bus.count), 8'h01);
    tick(19);
    chk("rep.before_first", 8'(bus.count), 8'h01);
    tick(1);
    chk("rep.first", 8'(bus.count), 8'h02);
    tick(8);
    chk("rep.second", 8'(bus.count), 8'h03);
    tick(8);
    chk("rep.third", 8'(bus.count), 8'h04);
    tick(4);
    bus.key_down = 1'b0;
    tick(20);
    check_all("rep.final", 3'd4, 1'b1, 4'hA, 1'b1, 1'b0, 8'h60);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rep.entry%0d", i), 8'(bus.rd_data), 8'h0A);
      pop();
      chk($sformatf("rep.diods%0d", i), 8'(bus.diods[3:0]), 8'h0A);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
